// File: rtl/dm_cache_pkg.sv
// Shared constants and FSM state type for the direct-mapped cache.
package dm_cache_pkg;

    // Field widths for the default geometry: 8 sets of 32-byte lines.
    localparam int TAG_W  = 24;
    localparam int IDX_W  = 3;
    localparam int OFF_W  = 5;
    localparam int LINE_W = 256;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        WRITEBACK,
        FILL
    } state_e;

endpackage : dm_cache_pkg

// File: rtl/dm_cache_array.sv
// Line storage: per-set valid/dirty bits, tag and data arrays with a
// combinational read port, a byte-masked word write port and a full-line
// fill port.
module dm_cache_array
    import dm_cache_pkg::*;
#(
    parameter int IDX_BITS  = IDX_W,
    parameter int TAG_BITS  = TAG_W,
    parameter int LINE_BITS = LINE_W
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [IDX_BITS-1:0]                    idx_i,
    output logic                                   valid_o,
    output logic                                   dirty_o,
    output logic [TAG_BITS-1:0]                    tag_o,
    output logic [LINE_BITS-1:0]                   line_o,
    input  logic                                   word_we_i,
    input  logic [$clog2(LINE_BITS/WORD_W)-1:0]    word_sel_i,
    input  logic [3:0]                             word_be_i,
    input  logic [WORD_W-1:0]                      word_wdata_i,
    input  logic                                   fill_we_i,
    input  logic [TAG_BITS-1:0]                    fill_tag_i,
    input  logic [LINE_BITS-1:0]                   fill_line_i,
    input  logic                                   clean_i
);

    localparam int NUM_SETS = 1 << IDX_BITS;

    logic [NUM_SETS-1:0]  valid_q, valid_d;
    logic [NUM_SETS-1:0]  dirty_q, dirty_d;
    logic [TAG_BITS-1:0]  tag_q  [NUM_SETS];
    logic [LINE_BITS-1:0] data_q [NUM_SETS];

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign line_o  = data_q[idx_i];

    // Next-state of the status bits: a fill validates and cleans the set,
    // a CPU write dirties it, a completed writeback cleans it.
    always_comb begin
        // NOTE: every variable gets its hold value first, so no path leaves
        // it unassigned and no latch is inferred.
        valid_d = valid_q;
        dirty_d = dirty_q;
        // NOTE: blocking '=' here because later statements must see the
        // earlier updates; clocked state below uses '<=' only.
        if (fill_we_i) begin
            valid_d[idx_i] = 1'b1;
            dirty_d[idx_i] = 1'b0;
        end
        if (word_we_i) begin
            dirty_d[idx_i] = 1'b1;
        end
        if (clean_i) begin
            dirty_d[idx_i] = 1'b0;
        end
    end

    // Status bit registers; reset invalidates and cleans every set.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data arrays: whole-line fill or byte-masked single-word write.
    // NOTE: these memories are deliberately not reset; a cleared valid bit
    // makes their stale contents unobservable.
    always_ff @(posedge clk) begin
        if (fill_we_i) begin
            tag_q[idx_i]  <= fill_tag_i;
            data_q[idx_i] <= fill_line_i;
        end else if (word_we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (word_be_i[b]) begin
                    data_q[idx_i][WORD_W*int'(word_sel_i) + 8*b +: 8] <= word_wdata_i[8*b +: 8];
                end
            end
        end
    end

endmodule : dm_cache_array

// File: rtl/dm_cache.sv
// Direct-mapped, write-back, write-allocate cache: request latch, control
// FSM and datapath around the dm_cache_array storage.
module dm_cache
    import dm_cache_pkg::*;
#(
    parameter int S_INDEX  = 3,
    parameter int S_OFFSET = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_read,
    input  logic                       mem_write,
    input  logic [31:0]                mem_address,
    input  logic [3:0]                 mem_byte_enable,
    input  logic [31:0]                mem_wdata,
    output logic [31:0]                mem_rdata,
    output logic                       mem_resp,
    output logic                       pmem_read,
    output logic                       pmem_write,
    output logic [31:0]                pmem_address,
    output logic [(8<<S_OFFSET)-1:0]   pmem_wdata,
    input  logic [(8<<S_OFFSET)-1:0]   pmem_rdata,
    input  logic                       pmem_resp
);

    localparam int TAG_BITS  = 32 - S_INDEX - S_OFFSET;
    localparam int LINE_BITS = 8 << S_OFFSET;
    localparam int SEL_BITS  = S_OFFSET - 2;

    state_e        state_q, state_d;
    logic [31:2]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic          is_write_q, is_write_d;

    // Byte-lane bits of the CPU address carry no information for word access.
    logic          unused_addr_lsbs;
    assign unused_addr_lsbs = &{1'b0, mem_address[1:0]};

    // Fields of the latched request address.
    logic [TAG_BITS-1:0] req_tag;
    logic [S_INDEX-1:0]  req_idx;
    logic [SEL_BITS-1:0] req_word;
    assign req_tag  = addr_q[31 -: TAG_BITS];
    assign req_idx  = addr_q[S_OFFSET +: S_INDEX];
    assign req_word = addr_q[2 +: SEL_BITS];

    // Storage read port and write controls.
    logic                 arr_valid, arr_dirty;
    logic [TAG_BITS-1:0]  arr_tag;
    logic [LINE_BITS-1:0] arr_line;
    logic                 word_we, fill_we, clean;
    logic                 hit;

    assign hit = arr_valid && (arr_tag == req_tag);

    dm_cache_array #(
        .IDX_BITS  (S_INDEX),
        .TAG_BITS  (TAG_BITS),
        .LINE_BITS (LINE_BITS)
    ) u_array (
        .clk          (clk),
        .rst          (rst),
        .idx_i        (req_idx),
        .valid_o      (arr_valid),
        .dirty_o      (arr_dirty),
        .tag_o        (arr_tag),
        .line_o       (arr_line),
        .word_we_i    (word_we),
        .word_sel_i   (req_word),
        .word_be_i    (be_q),
        .word_wdata_i (wdata_q),
        .fill_we_i    (fill_we),
        .fill_tag_i   (req_tag),
        .fill_line_i  (pmem_rdata),
        .clean_i      (clean)
    );

    // Next-state, request latch and all outputs; outputs are zero unless the
    // current state drives them, so IDLE (including just after reset) is quiet.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        is_write_d   = is_write_q;
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        word_we      = 1'b0;
        fill_we      = 1'b0;
        clean        = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    addr_d     = mem_address[31:2];
                    wdata_d    = mem_wdata;
                    be_d       = mem_byte_enable;
                    // A simultaneous read and write is treated as a write.
                    is_write_d = mem_write;
                    state_d    = CHECK;
                end
            end
            CHECK: begin
                if (hit) begin
                    mem_resp  = 1'b1;
                    // Pre-write word is returned even on a write hit.
                    mem_rdata = arr_line[WORD_W*int'(req_word) +: WORD_W];
                    word_we   = is_write_q;
                    state_d   = IDLE;
                end else if (arr_valid && arr_dirty) begin
                    state_d = WRITEBACK;
                end else begin
                    state_d = FILL;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {arr_tag, req_idx, {S_OFFSET{1'b0}}};
                pmem_wdata   = arr_line;
                if (pmem_resp) begin
                    clean   = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag, req_idx, {S_OFFSET{1'b0}}};
                if (pmem_resp) begin
                    fill_we = 1'b1;
                    state_d = CHECK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and request registers; reset abandons any memory transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            is_write_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            is_write_q <= is_write_d;
        end
    end

endmodule : dm_cache

// File: tb/tb_dm_cache.sv
// Directed self-checking bench for dm_cache with a behavioural line memory.
module tb_dm_cache;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_read, mem_write;
    logic [31:0]  mem_address;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    int checks   = 0;
    int failures = 0;

    // Observations collected by do_access for the last transaction.
    int           wb_count, fill_count;
    logic [31:0]  wb_addr, fill_addr;
    logic [255:0] wb_data;
    bit           overlap_seen, wb_before_fill, extra_resp;

    logic [255:0] pmem_model [bit [31:0]];

    dm_cache dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_byte_enable (mem_byte_enable),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] make_line(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = base + 32'(i);
        return l;
    endfunction

    function automatic logic [31:0] word_of(input logic [255:0] l, input int i);
        return l[32*i +: 32];
    endfunction

    function automatic logic [255:0] model_line(input logic [31:0] a);
        if (pmem_model.exists(a)) return pmem_model[a];
        return '0;
    endfunction

    // One CPU access, starting just after a falling edge; services line
    // fills/writebacks from the model with a two-cycle memory latency.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] wd,
                             output logic [31:0] rdata, output int edges, output bit done);
        int pm_wait;
        rdata = '0; edges = 0; done = 0; pm_wait = 0;
        wb_count = 0; fill_count = 0; overlap_seen = 0; wb_before_fill = 0;
        wb_addr = '0; fill_addr = '0; wb_data = '0;
        mem_read = rd; mem_write = wr; mem_address = addr;
        mem_byte_enable = be; mem_wdata = wd;
        while (!done && edges < 60) begin
            @(posedge clk); edges++;
            @(negedge clk);
            pmem_resp = 1'b0;
            if (pmem_read && pmem_write) overlap_seen = 1;
            if (mem_resp) begin
                rdata = mem_rdata; done = 1;
                mem_read = 1'b0; mem_write = 1'b0;
            end else if (pmem_read || pmem_write) begin
                pm_wait++;
                if (pm_wait == 2) begin
                    pm_wait = 0;
                    if (pmem_write) begin
                        wb_count++; wb_addr = pmem_address; wb_data = pmem_wdata;
                        pmem_model[pmem_address] = pmem_wdata;
                    end else begin
                        fill_count++; fill_addr = pmem_address;
                        if (wb_count > 0) wb_before_fill = 1;
                        pmem_rdata = model_line(pmem_address);
                    end
                    pmem_resp = 1'b1;
                end
            end
        end
        mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
        @(posedge clk); @(negedge clk);
        extra_resp = mem_resp;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_read = 0; mem_write = 0; mem_address = '0; mem_byte_enable = '0; mem_wdata = '0;
        pmem_rdata = '0; pmem_resp = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (mem_resp !== 1'b0) begin failures++; $display("FAIL reset_mem_resp: got %b want 0", mem_resp); end
        checks++; if (pmem_read !== 1'b0) begin failures++; $display("FAIL reset_pmem_read: got %b want 0", pmem_read); end
        checks++; if (pmem_write !== 1'b0) begin failures++; $display("FAIL reset_pmem_write: got %b want 0", pmem_write); end
        checks++; if (mem_rdata !== 32'h0) begin failures++; $display("FAIL reset_mem_rdata: got %h want 0", mem_rdata); end
        checks++; if (pmem_address !== 32'h0) begin failures++; $display("FAIL reset_pmem_address: got %h want 0", pmem_address); end
    endtask

    task automatic test_cold_read();
        logic [31:0] rd; int e; bit ok;
        do_access(1, 0, 32'h0000_0104, 4'h0, 32'h0, rd, e, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL cold_done: got %b want 1 (timeout)", ok); end
        checks++; if (fill_count !== 1) begin failures++; $display("FAIL cold_fill_count: got %0d want 1", fill_count); end
        checks++; if (fill_addr !== 32'h0000_0100) begin failures++; $display("FAIL cold_fill_addr: got %h want 00000100", fill_addr); end
        checks++; if (wb_count !== 0) begin failures++; $display("FAIL cold_wb_count: got %0d want 0", wb_count); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL cold_rdata: got %h want deadbeef", rd); end
        checks++; if (extra_resp !== 1'b0) begin failures++; $display("FAIL cold_single_resp: got %b want 0", extra_resp); end
    endtask

    task automatic test_hit_read();
        logic [31:0] rd; int e; bit ok;
        do_access(1, 0, 32'h0000_0104, 4'h0, 32'h0, rd, e, ok);
        // Response seen after the first edge is captured by the CPU on the second.
        checks++; if (e + 1 !== 2 || !ok) begin failures++; $display("FAIL hit_latency: got %0d want 2 (done=%b)", e + 1, ok); end
        checks++; if (fill_count + wb_count !== 0) begin failures++; $display("FAIL hit_no_pmem: got %0d transfers want 0", fill_count + wb_count); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL hit_rdata: got %h want deadbeef", rd); end
    endtask

    task automatic test_write_hit();
        logic [31:0] rd; int e; bit ok;
        do_access(0, 1, 32'h0000_0104, 4'b0011, 32'h1234_5678, rd, e, ok);
        checks++; if (rd !== 32'hDEAD_BEEF || !ok) begin failures++; $display("FAIL write_prewrite_rdata: got %h want deadbeef", rd); end
        checks++; if (e !== 1 || fill_count + wb_count !== 0) begin failures++; $display("FAIL write_hit_quiet: edges %0d transfers %0d want 1/0", e, fill_count + wb_count); end
        do_access(1, 0, 32'h0000_0104, 4'h0, 32'h0, rd, e, ok);
        checks++; if (rd !== 32'hDEAD_5678) begin failures++; $display("FAIL write_readback: got %h want dead5678", rd); end
        do_access(0, 1, 32'h0000_010C, 4'b1010, 32'h1122_3344, rd, e, ok);
        do_access(1, 0, 32'h0000_010C, 4'h0, 32'h0, rd, e, ok);
        checks++; if (rd !== 32'h1100_3303) begin failures++; $display("FAIL write_sparse_be: got %h want 11003303", rd); end
    endtask

    task automatic test_conflict_miss();
        logic [31:0] rd; int e; bit ok;
        do_access(1, 0, 32'h0000_1104, 4'h0, 32'h0, rd, e, ok);
        checks++; if (wb_count !== 1 || wb_addr !== 32'h0000_0100) begin failures++; $display("FAIL conflict_wb_addr: count %0d addr %h want 1/00000100", wb_count, wb_addr); end
        checks++; if (word_of(wb_data, 1) !== 32'hDEAD_5678) begin failures++; $display("FAIL conflict_wb_word1: got %h want dead5678", word_of(wb_data, 1)); end
        checks++; if (word_of(wb_data, 3) !== 32'h1100_3303 || word_of(wb_data, 0) !== 32'h1000_0000) begin
            failures++; $display("FAIL conflict_wb_words: w0 %h w3 %h want 10000000/11003303", word_of(wb_data, 0), word_of(wb_data, 3)); end
        checks++; if (fill_count !== 1 || fill_addr !== 32'h0000_1100 || !wb_before_fill) begin
            failures++; $display("FAIL conflict_fill: count %0d addr %h order %b want 1/00001100/1", fill_count, fill_addr, wb_before_fill); end
        checks++; if (rd !== 32'hCAFE_F00D || !ok) begin failures++; $display("FAIL conflict_rdata: got %h want cafef00d", rd); end
        checks++; if (overlap_seen) begin failures++; $display("FAIL conflict_overlap: pmem_read and pmem_write both high"); end
        // Clean victim: swap back with a fill only, data comes from memory.
        do_access(1, 0, 32'h0000_0104, 4'h0, 32'h0, rd, e, ok);
        checks++; if (wb_count !== 0 || fill_count !== 1 || rd !== 32'hDEAD_5678) begin
            failures++; $display("FAIL clean_swap: wb %0d fill %0d rdata %h want 0/1/dead5678", wb_count, fill_count, rd); end
    endtask

    task automatic test_reset_during_fill();
        logic [31:0] rd; int e; bit ok; bit seen;
        seen = 0;
        mem_read = 1; mem_address = 32'h0000_2104;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (pmem_read) seen = 1;
        end
        checks++; if (!seen || pmem_address !== 32'h0000_2100) begin failures++; $display("FAIL rstfill_reach: seen %b addr %h want 1/00002100", seen, pmem_address); end
        rst = 1; mem_read = 0;
        @(negedge clk);
        rst = 0;
        checks++; if ({mem_resp, pmem_read, pmem_write} !== 3'b000 || pmem_address !== 32'h0) begin
            failures++; $display("FAIL rstfill_idle: resp/rd/wr %b addr %h want 000/0", {mem_resp, pmem_read, pmem_write}, pmem_address); end
        pmem_rdata = {8{32'hBAD0_BAD0}}; pmem_resp = 1;
        @(negedge clk);
        pmem_resp = 0;
        checks++; if ({mem_resp, pmem_read, pmem_write} !== 3'b000 || mem_rdata !== 32'h0) begin
            failures++; $display("FAIL rstfill_late_resp: resp/rd/wr %b rdata %h want 000/0", {mem_resp, pmem_read, pmem_write}, mem_rdata); end
        do_access(1, 0, 32'h0000_2104, 4'h0, 32'h0, rd, e, ok);
        checks++; if (fill_count !== 1 || rd !== 32'h2100_0001 || !ok) begin
            failures++; $display("FAIL rstfill_remiss: fill %0d rdata %h want 1/21000001", fill_count, rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; int e; bit ok;
        do_access(1, 1, 32'h0000_2108, 4'b1111, 32'hAABB_CCDD, rd, e, ok);
        checks++; if (rd !== 32'h2100_0002 || e !== 1 || !ok) begin failures++; $display("FAIL rdwr_resp: rdata %h edges %0d want 21000002/1", rd, e); end
        checks++; if (extra_resp !== 1'b0 || fill_count + wb_count !== 0) begin
            failures++; $display("FAIL rdwr_single: extra %b transfers %0d want 0/0", extra_resp, fill_count + wb_count); end
        do_access(1, 0, 32'h0000_2108, 4'h0, 32'h0, rd, e, ok);
        checks++; if (rd !== 32'hAABB_CCDD) begin failures++; $display("FAIL rdwr_written: got %h want aabbccdd", rd); end
        do_access(1, 0, 32'h0000_0108, 4'h0, 32'h0, rd, e, ok);
        checks++; if (wb_count !== 1 || wb_addr !== 32'h0000_2100 || word_of(wb_data, 2) !== 32'hAABB_CCDD) begin
            failures++; $display("FAIL rdwr_dirty_wb: count %0d addr %h w2 %h want 1/00002100/aabbccdd", wb_count, wb_addr, word_of(wb_data, 2)); end
        checks++; if (rd !== 32'h1000_0002 || fill_addr !== 32'h0000_0100) begin
            failures++; $display("FAIL rdwr_refill: rdata %h addr %h want 10000002/00000100", rd, fill_addr); end
    endtask

    initial begin
        logic [255:0] l;
        l = make_line(32'h1000_0000); l[63:32] = 32'hDEAD_BEEF; pmem_model[32'h0000_0100] = l;
        l = make_line(32'h1100_0000); l[63:32] = 32'hCAFE_F00D; pmem_model[32'h0000_1100] = l;
        pmem_model[32'h0000_2100] = make_line(32'h2100_0000);

        test_reset();
        test_cold_read();
        test_hit_read();
        test_write_hit();
        test_conflict_miss();
        test_reset_during_fill();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule : tb_dm_cache
